// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS-subset controller:
//            FSM state codes, opcode/funct values, instruction-class indices
//            and the datapath mux/ALU select encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Controller states. Codes 5..7 are unused and recover to FETCH.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Primary opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] c_FN_JR   = 6'h08;
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUBU = 6'h23;

  // One-hot instruction class bit positions
  localparam int c_CLS_W    = 11;
  localparam int c_CLS_ADDU = 0;
  localparam int c_CLS_SUBU = 1;
  localparam int c_CLS_ORI  = 2;
  localparam int c_CLS_LW   = 3;
  localparam int c_CLS_SW   = 4;
  localparam int c_CLS_LUI  = 5;
  localparam int c_CLS_BEQ  = 6;
  localparam int c_CLS_J    = 7;
  localparam int c_CLS_JAL  = 8;
  localparam int c_CLS_JR   = 9;
  localparam int c_CLS_NOP  = 10;

  // ALU operation select
  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;
  localparam logic [3:0] c_ALU_OR  = 4'b0010;

  // PC source select
  localparam logic [1:0] c_PC_PLUS4  = 2'b00;
  localparam logic [1:0] c_PC_BRANCH = 2'b01;
  localparam logic [1:0] c_PC_JUMP   = 2'b10;
  localparam logic [1:0] c_PC_REG    = 2'b11;

  // GPR write-register select
  localparam logic [1:0] c_RD_RT = 2'b00;
  localparam logic [1:0] c_RD_RD = 2'b01;
  localparam logic [1:0] c_RD_RA = 2'b10;

  // Immediate extension select
  localparam logic [1:0] c_EXT_ZERO = 2'b00;
  localparam logic [1:0] c_EXT_LUI  = 2'b01;
  localparam logic [1:0] c_EXT_SIGN = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Purely combinational Op/Funct decoder producing a one-hot
//            instruction class. Anything unsupported maps to the NOP class.
// Ports    : op_i    [5:0]  opcode field
//            funct_i [5:0]  funct field (R-type only)
//            cls_o   [10:0] one-hot class, bit positions from mc_pkg
// Revision : 1.0 - initial release
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]         op_i,
  input  logic [5:0]         funct_i,
  output logic [c_CLS_W-1:0] cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      c_OP_RTYPE: begin
        case (funct_i)
          c_FN_ADDU: cls_o[c_CLS_ADDU] = 1'b1;
          c_FN_SUBU: cls_o[c_CLS_SUBU] = 1'b1;
          c_FN_JR:   cls_o[c_CLS_JR]   = 1'b1;
          default:   cls_o[c_CLS_NOP]  = 1'b1;
        endcase
      end
      c_OP_ORI: cls_o[c_CLS_ORI] = 1'b1;
      c_OP_LW:  cls_o[c_CLS_LW]  = 1'b1;
      c_OP_SW:  cls_o[c_CLS_SW]  = 1'b1;
      c_OP_LUI: cls_o[c_CLS_LUI] = 1'b1;
      c_OP_BEQ: cls_o[c_CLS_BEQ] = 1'b1;
      c_OP_J:   cls_o[c_CLS_J]   = 1'b1;
      c_OP_JAL: cls_o[c_CLS_JAL] = 1'b1;
      default:  cls_o[c_CLS_NOP] = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS-subset control unit. Five-state FSM
//            (FETCH/DECODE/EXE/MEM/WB) driving datapath strobes and selects,
//            plus a 32-bit retired-instruction counter.
// Ports    : clk, reset (async, active-high)
//            Op, Funct       instruction fields from IR
//            Zero            ALU equality flag (used in EXE for beq only)
//            mem_ready       memory access completes this cycle
//            PCWrite/PCSrc, IRWrite, MemReq, MemWrite, RegWrite/RegDst,
//            MemtoReg, ALUSrc, ExtOp, ALUOp   datapath controls
//            State           current FSM state (debug)
//            InstrCnt        retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ExtOp,
  output logic [3:0]  ALUOp,
  output logic [2:0]  State,
  output logic [31:0] InstrCnt
);

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [c_CLS_W-1:0]  w_cls;
  logic                w_retire;
  logic                w_pcw, w_irw, w_mreq, w_mw, w_rw;

  mc_decode u_decode (
    .op_i    (Op),
    .funct_i (Funct),
    .cls_o   (w_cls)
  );

  // Outputs depend on the current state and, in FETCH/MEM/EXE-beq, on the
  // same-cycle mem_ready/Zero inputs, so they are decoded combinationally
  // from the state register rather than registered.
  always_comb begin
    state_d  = ST_FETCH;
    w_retire = 1'b0;
    w_pcw    = 1'b0;
    w_irw    = 1'b0;
    w_mreq   = 1'b0;
    w_mw     = 1'b0;
    w_rw     = 1'b0;
    PCSrc    = c_PC_PLUS4;
    RegDst   = c_RD_RT;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = c_EXT_ZERO;
    ALUOp    = c_ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        w_mreq = 1'b1;
        if (mem_ready) begin
          w_irw   = 1'b1;
          w_pcw   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (w_cls[c_CLS_J] || w_cls[c_CLS_JAL]) begin
          w_pcw = 1'b1;
          PCSrc = c_PC_JUMP;
        end
        if (w_cls[c_CLS_JAL]) begin
          w_rw   = 1'b1;
          RegDst = c_RD_RA;
        end
        if (w_cls[c_CLS_JR]) begin
          w_pcw = 1'b1;
          PCSrc = c_PC_REG;
        end
        // Jumps and NOPs complete here; everything else needs the ALU.
        if (w_cls[c_CLS_J] || w_cls[c_CLS_JAL] || w_cls[c_CLS_JR] || w_cls[c_CLS_NOP]) begin
          w_retire = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (w_cls[c_CLS_SUBU] || w_cls[c_CLS_BEQ]) begin
          ALUOp = c_ALU_SUB;
        end
        if (w_cls[c_CLS_ORI]) begin
          ALUOp  = c_ALU_OR;
          ALUSrc = 1'b1;
          ExtOp  = c_EXT_ZERO;
        end
        if (w_cls[c_CLS_LUI]) begin
          ALUSrc = 1'b1;
          ExtOp  = c_EXT_LUI;
        end
        if (w_cls[c_CLS_LW] || w_cls[c_CLS_SW]) begin
          ALUSrc = 1'b1;
          ExtOp  = c_EXT_SIGN;
        end
        if (w_cls[c_CLS_BEQ]) begin
          w_pcw    = Zero;
          PCSrc    = c_PC_BRANCH;
          w_retire = 1'b1;
          state_d  = ST_FETCH;
        end else if (w_cls[c_CLS_LW] || w_cls[c_CLS_SW]) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        w_mreq = 1'b1;
        w_mw   = w_cls[c_CLS_SW];
        if (!mem_ready) begin
          state_d = ST_MEM;
        end else if (w_cls[c_CLS_SW]) begin
          w_retire = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        w_rw     = 1'b1;
        RegDst   = (w_cls[c_CLS_ADDU] || w_cls[c_CLS_SUBU]) ? c_RD_RD : c_RD_RT;
        MemtoReg = w_cls[c_CLS_LW];
        w_retire = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign cnt_d = w_retire ? (cnt_q + 32'd1) : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FETCH itself asserts MemReq, so strobes are also masked by reset
  // directly to keep them quiet for the whole time reset is held.
  assign PCWrite  = w_pcw  & ~reset;
  assign IRWrite  = w_irw  & ~reset;
  assign MemReq   = w_mreq & ~reset;
  assign MemWrite = w_mw   & ~reset;
  assign RegWrite = w_rw   & ~reset;
  assign State    = state_q;
  assign InstrCnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces block to reset state immediately.
REQ-003 Op  in  6  opcode field of instruction register (IR), valid from DECODE onward.
REQ-004 Funct  in  6  funct field of IR, valid from DECODE onward.
REQ-005 Zero  in  1  ALU equality flag, sampled only in EXE for beq.
REQ-006 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-007 PCWrite  out  1  load PC this cycle.
REQ-008 PCSrc  out  2  PC source: 00 PC+4, 01 branch target, 10 jump imm26, 11 GPR[rs].
REQ-009 IRWrite  out  1  load IR from memory data this cycle.
REQ-010 MemReq  out  1  memory access request (fetch or data).
REQ-011 MemWrite  out  1  data store strobe.
REQ-012 RegWrite  out  1  GPR write strobe.
REQ-013 RegDst  out  2  write register: 00 rt, 01 rd, 10 $31.
REQ-014 MemtoReg  out  1  GPR write data from memory.
REQ-015 ALUSrc  out  1  ALU B operand: 0 GPR[rt], 1 extended immediate.
REQ-016 ExtOp  out  2  00 zero-extend, 01 imm<<16, 10 sign-extend.
REQ-017 ALUOp  out  4  0000 add, 0001 sub, 0010 or; others reserved.
REQ-018 State  out  3  current state, debug only.
REQ-019 InstrCnt  out  32  retired-instruction counter.

Function
REQ-020 FSM states: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; codes 5-7 illegal, next state FETCH.
REQ-021 Supported: addu, subu, ori, lw, sw, lui, beq, j, jal, jr; anything else is NOP.
REQ-022 FETCH: MemReq=1; stay while mem_ready=0; when mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00, next DECODE.
REQ-023 DECODE: j -> PCWrite=1, PCSrc=10; jal -> same plus RegWrite=1, RegDst=10 (writes PC+4); jr -> PCWrite=1, PCSrc=11; these and NOP retire, next FETCH; all others next EXE.
REQ-024 EXE: addu ALUOp=add; subu and beq ALUOp=sub; ori ALUOp=or, ALUSrc=1, ExtOp=00; lui ALUSrc=1, ExtOp=01, ALUOp=add; lw/sw ALUSrc=1, ExtOp=10, ALUOp=add.
REQ-025 EXE beq: PCWrite=Zero, PCSrc=01; retire, next FETCH. lw/sw next MEM; others next WB.
REQ-026 MEM: MemReq=1, MemWrite=sw; stay while mem_ready=0; on mem_ready=1 lw -> WB, sw retires -> FETCH.
REQ-027 WB: RegWrite=1; RegDst=01 for addu/subu, 00 otherwise; MemtoReg=lw; retire, next FETCH.
REQ-028 All strobes not listed for a state/instruction are 0; mux selects are 0 where unspecified.
REQ-029 Latency with mem_ready=1: j/jal/jr/NOP 2, beq 3, R-type/ori/lui 4, sw 4, lw 5 cycles.
REQ-030 mem_ready is ignored in DECODE, EXE and WB; Zero ignored outside EXE-beq.
REQ-031 InstrCnt increments by 1 on the edge leaving the retiring state; wraps 0xFFFFFFFF -> 0.
REQ-032 Instruction class is decoded from Op/Funct combinationally each state; IR stability is the datapath's duty (IRWrite only in FETCH).

Reset
REQ-033 While reset=1: State=FETCH, InstrCnt=0, every strobe (PCWrite, IRWrite, MemReq, MemWrite, RegWrite) forced 0.
REQ-034 Reset asserted mid-instruction (including MEM wait) abandons it without retirement; first cycle after release is FETCH.

Structure
REQ-035 Package mc_pkg holds state encodings, opcode/funct constants, ALUOp, PCSrc, RegDst, ExtOp encodings.
REQ-036 One sub-module mc_decode: purely combinational Op/Funct -> one-hot instruction class; FSM and counter in mc_ctrl.

Verification
REQ-037 addu (Op=00,Funct=21), mem_ready=1 -> states 0,1,2,4,0; RegWrite=1,RegDst=01 only in WB; InstrCnt 0->1.
REQ-038 lw (Op=23) with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with MemtoReg=1; total 8 cycles.
REQ-039 beq (Op=04): Zero=1 -> PCWrite=1,PCSrc=01 in EXE; Zero=0 -> PCWrite=0; both retire in 3 cycles.
REQ-040 jal (Op=03) -> DECODE: PCWrite=1,PCSrc=10,RegWrite=1,RegDst=10; back to FETCH; NOP Op=3F retires in 2 cycles with no strobes in DECODE.
REQ-041 reset pulsed during sw MEM wait -> strobes 0 immediately, State=0, InstrCnt=0, no MemWrite issued.
REQ-042 Preload counter path to 0xFFFFFFFF via retirements (or force) then retire one j -> InstrCnt=0.
